// File: rtl/mv_sched_pkg.sv
// Shared types and bit-layout constants for the two-source matrix-vector scheduler.
// Matrices are row-major; row 0 and field 0 sit at the MSB end.
package mv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } SCHED_STATE_t;

  localparam int FLD_W = 32;
  localparam int ROW_W = 4 * FLD_W;
  localparam int MAT_W = 4 * ROW_W;

  function automatic int row_lsb(input int row);
    return MAT_W - ROW_W * (row + 1);
  endfunction

endpackage

// File: rtl/xform_out_fifo.sv
// Result FIFO: pushes unconditionally, pops on pop & valid, zero data while empty.
// Read data is combinational from the head entry.
module xform_out_fifo #(
  parameter int W     = 137,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign data   = valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= ptr_inc(wp);
      if (do_pop) rp <= ptr_inc(rp);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mv_xform_sched.sv
// Round-robin burst scheduler feeding a shared 4x4 matrix-vector pipeline, reloading the
// matrix on source change or after a row rewrite; credit-metered issue into a result FIFO.
module mv_xform_sched
  import mv_sched_pkg::*;
#(
  parameter int IDW    = 8,
  parameter int DEPTH  = 8,
  parameter int DP_LAT = 5,
  parameter int BURST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic             cfg_src,
  input  logic [1:0]       cfg_row,
  input  logic [ROW_W-1:0] cfg_data,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDW-1:0]   req0_id,
  input  logic [ROW_W-1:0] req0_v,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDW-1:0]   req1_id,
  input  logic [ROW_W-1:0] req1_v,
  output logic             dp_m_valid,
  output logic [MAT_W-1:0] dp_m,
  output logic             dp_in_valid,
  output logic [IDW:0]     dp_in_id,
  output logic [ROW_W-1:0] dp_v,
  input  logic             dp_out_valid,
  input  logic [IDW:0]     dp_out_id,
  input  logic [ROW_W-1:0] dp_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [IDW-1:0]   out_id,
  output logic [ROW_W-1:0] out_v
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int FW = IDW + 1 + ROW_W;

  if (DEPTH < DP_LAT + 1) begin : g_depth_chk
    $error("DEPTH must cover the datapath latency plus one");
  end

  SCHED_STATE_t state, state_nxt;
  logic [ROW_W-1:0] mat [2][4];
  logic [BW-1:0]    burst_cnt, burst_nxt;
  logic [CW-1:0]    inflight, fifo_count;
  logic             loaded_src, dirty, dirty_nxt, last_src;
  logic             gsrc, greq_valid, other_valid, credit_ok, issue, new_loaded;
  logic [FW-1:0]    fifo_data;

  assign gsrc        = (state == RUN1);
  assign greq_valid  = gsrc ? req1_valid : req0_valid;
  assign other_valid = gsrc ? req0_valid : req1_valid;
  // Reserve a FIFO slot for every vertex still inside the pipeline.
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
  assign issue       = (state != IDLE) && greq_valid && credit_ok;

  assign req0_ready  = issue && !gsrc;
  assign req1_ready  = issue && gsrc;
  assign dp_in_valid = issue;
  assign dp_in_id    = issue ? {gsrc, (gsrc ? req1_id : req0_id)} : '0;
  assign dp_v        = issue ? (gsrc ? req1_v : req0_v) : '0;
  assign dp_m_valid  = issue && ((gsrc != loaded_src) || dirty);

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign dp_m[row_lsb(r) +: ROW_W] = mat[gsrc][r];
  end

  // A row write to whichever matrix the datapath holds after this edge forces a reload.
  assign new_loaded = issue ? gsrc : loaded_src;
  assign dirty_nxt  = (cfg_valid && (cfg_src == new_loaded)) || (dirty && !issue);

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (issue && (burst_cnt < BW'(BURST))) burst_nxt = burst_cnt + BW'(1);
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = last_src ? RUN0 : RUN1;
        else if (req0_valid)          state_nxt = RUN0;
        else if (req1_valid)          state_nxt = RUN1;
      end
      RUN0, RUN1: begin
        if (other_valid && (!greq_valid || (burst_nxt == BW'(BURST))))
          state_nxt = gsrc ? RUN0 : RUN1;
        else if (!greq_valid && !other_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_src   <= 1'b1;
      loaded_src <= 1'b0;
      dirty      <= 1'b1;
      inflight   <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= (state_nxt != state) ? '0 : burst_nxt;
      dirty      <= dirty_nxt;
      loaded_src <= new_loaded;
      if (issue) last_src <= gsrc;
      if (issue && !dp_out_valid)      inflight <= inflight + CW'(1);
      else if (!issue && dp_out_valid) inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++)
        for (int r = 0; r < 4; r++) mat[s][r] <= '0;
    end else if (cfg_valid) begin
      mat[cfg_src][cfg_row] <= cfg_data;
    end
  end

  xform_out_fifo #(.W(FW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dp_out_valid),
    .push_data ({dp_out_id, dp_o}),
    .pop       (out_ready),
    .valid     (out_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign out_src = fifo_data[FW-1];
  assign out_id  = fifo_data[FW-2 -: IDW];
  assign out_v   = fifo_data[ROW_W-1:0];

endmodule
